// File: rtl/control_sequencer.sv
// Fetch/decode/execute control unit: walks RESET -> T0..T7 -> (T0 | HALT) and
// decodes the datapath strobes from the current step, the opcode and the memory/branch flags.
module control_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic                  con_ff,
    input  logic                  mem_ready,
    output logic                  pc_out,
    output logic                  pc_in,
    output logic                  inc_pc,
    output logic                  mar_in,
    output logic                  mdr_in,
    output logic                  mdr_out,
    output logic                  read,
    output logic                  write,
    output logic                  ir_in,
    output logic                  y_in,
    output logic                  z_in,
    output logic                  z_low_out,
    output logic                  gra,
    output logic                  grb,
    output logic                  grc,
    output logic                  r_in,
    output logic                  r_out,
    output logic                  ba_out,
    output logic                  c_out,
    output logic                  con_in,
    output logic [4:0]            alu_op,
    output logic                  run,
    output logic                  illegal
);

    typedef enum logic [1:0] {PH_RESET, PH_RUN, PH_HALT} phase_t;
    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_RALU, C_IALU, C_BR, C_JR, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    phase_t     phase;
    logic [2:0] step;
    logic       illegal_hold;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir;

    always_comb begin
        op_class = C_ILLEGAL;
        if (opcode == 5'b00000)                           op_class = C_LD;
        else if (opcode == 5'b00001)                      op_class = C_LDI;
        else if (opcode == 5'b00010)                      op_class = C_ST;
        else if (opcode >= 5'b00011 && opcode <= 5'b01011) op_class = C_RALU;
        else if (opcode >= 5'b01100 && opcode <= 5'b01110) op_class = C_IALU;
        else if (opcode == 5'b10011)                      op_class = C_BR;
        else if (opcode == 5'b10100)                      op_class = C_JR;
        else if (opcode == 5'b11010)                      op_class = C_NOP;
        else if (opcode == 5'b11011)                      op_class = C_HALT;
    end

    // Only T1, T6 (ld) and T7 (st) can stall; every sequence returns to T0 explicitly.
    always_ff @(posedge clock) begin
        if (!clear) begin
            phase        <= PH_RESET;
            step         <= 3'd0;
            illegal_hold <= 1'b0;
        end else begin
            case (phase)
                PH_RESET: begin
                    phase <= PH_RUN;
                    step  <= 3'd0;
                end
                PH_HALT: phase <= PH_HALT;
                default: begin
                    case (step)
                        3'd0: step <= 3'd1;
                        3'd1: if (mem_ready) step <= 3'd2;
                        3'd2: step <= 3'd3;
                        3'd3: begin
                            case (op_class)
                                C_NOP, C_JR: step <= 3'd0;
                                C_HALT:      phase <= PH_HALT;
                                C_ILLEGAL: begin
                                    if (HALT_ON_ILLEGAL) begin
                                        phase        <= PH_HALT;
                                        illegal_hold <= 1'b1;
                                    end else begin
                                        step <= 3'd0;
                                    end
                                end
                                default:     step <= 3'd4;
                            endcase
                        end
                        3'd4: step <= 3'd5;
                        3'd5: begin
                            if (op_class == C_LD || op_class == C_ST || op_class == C_BR)
                                step <= 3'd6;
                            else
                                step <= 3'd0;
                        end
                        3'd6: begin
                            if (op_class == C_BR)                      step <= 3'd0;
                            else if (op_class == C_ST || mem_ready)    step <= 3'd7;
                        end
                        default: if (op_class == C_LD || mem_ready) step <= 3'd0;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
        mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0; write = 1'b0; ir_in = 1'b0;
        y_in = 1'b0; z_in = 1'b0; z_low_out = 1'b0; gra = 1'b0; grb = 1'b0;
        grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0; c_out = 1'b0;
        con_in = 1'b0; alu_op = 5'b00000;
        run     = (phase == PH_RUN);
        illegal = illegal_hold;
        if (phase == PH_RUN) begin
            case (step)
                3'd0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
                3'd1: begin z_low_out = 1'b1; read = 1'b1; mdr_in = 1'b1; pc_in = mem_ready; end
                3'd2: begin mdr_out = 1'b1; ir_in = 1'b1; end
                3'd3: begin
                    case (op_class)
                        C_RALU, C_IALU:    begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                        C_LD, C_LDI, C_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                        C_BR:              begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
                        C_JR:              begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
                        C_ILLEGAL:         illegal = 1'b1;
                        default:           ;
                    endcase
                end
                3'd4: begin
                    case (op_class)
                        C_RALU: begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = opcode; end
                        C_IALU: begin
                            c_out = 1'b1; z_in = 1'b1;
                            alu_op = (opcode == 5'b01100) ? 5'b00011 :
                                     (opcode == 5'b01101) ? 5'b00101 : 5'b00110;
                        end
                        C_LD, C_LDI, C_ST: begin c_out = 1'b1; z_in = 1'b1; alu_op = 5'b00011; end
                        C_BR:              begin pc_out = 1'b1; y_in = 1'b1; end
                        default:           ;
                    endcase
                end
                3'd5: begin
                    case (op_class)
                        C_LD, C_ST: begin z_low_out = 1'b1; mar_in = 1'b1; end
                        C_BR:       begin c_out = 1'b1; z_in = 1'b1; alu_op = 5'b00011; end
                        default:    begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    endcase
                end
                3'd6: begin
                    case (op_class)
                        C_LD:    begin read = 1'b1; mdr_in = 1'b1; end
                        C_ST:    begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
                        default: begin z_low_out = 1'b1; pc_in = con_ff; end
                    endcase
                end
                default: begin
                    if (op_class == C_LD) begin
                        mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end else begin
                        write = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle queues its hand-computed strobe
// vector, and a negedge monitor pops and compares it against the packed DUT outputs.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        con_ff = 1'b0;
    logic        mem_ready = 1'b0;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in;
    logic y_in, z_in, z_low_out, gra, grb, grc, r_in, r_out, ba_out, c_out, con_in;
    logic [4:0] alu_op;
    logic run, illegal;

    int checks = 0;
    int errors = 0;
    string       name_q[$];
    logic [26:0] vec_q[$];

    localparam logic [26:0] PC_OUT = 27'd1 << 26, PC_IN = 27'd1 << 25, INC_PC = 27'd1 << 24;
    localparam logic [26:0] MAR_IN = 27'd1 << 23, MDR_IN = 27'd1 << 22, MDR_OUT = 27'd1 << 21;
    localparam logic [26:0] READ = 27'd1 << 20, WRITE = 27'd1 << 19, IR_IN = 27'd1 << 18;
    localparam logic [26:0] Y_IN = 27'd1 << 17, Z_IN = 27'd1 << 16, Z_LOW_OUT = 27'd1 << 15;
    localparam logic [26:0] GRA = 27'd1 << 14, GRB = 27'd1 << 13, GRC = 27'd1 << 12;
    localparam logic [26:0] R_IN = 27'd1 << 11, R_OUT = 27'd1 << 10, BA_OUT = 27'd1 << 9;
    localparam logic [26:0] C_OUT = 27'd1 << 8, CON_IN = 27'd1 << 7;
    localparam logic [26:0] RUN = 27'd1 << 1, ILLEGAL = 27'd1;
    localparam logic [26:0] NONE = 27'd0;

    wire [26:0] actual = {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in,
                          y_in, z_in, z_low_out, gra, grb, grc, r_in, r_out, ba_out, c_out,
                          con_in, alu_op, run, illegal};

    control_sequencer #(.DATA_WIDTH(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .read(read), .write(write), .ir_in(ir_in), .y_in(y_in),
        .z_in(z_in), .z_low_out(z_low_out), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
        .r_out(r_out), .ba_out(ba_out), .c_out(c_out), .con_in(con_in), .alu_op(alu_op),
        .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [26:0] alu(input logic [4:0] op);
        return {20'd0, op, 2'b00};
    endfunction

    // Drives one cycle's inputs just after the rising edge and queues that cycle's expectation.
    task automatic applyStimulus(input string nm, input logic clr, input logic [31:0] irv,
                                 input logic mr, input logic cf, input logic [26:0] exp_vec);
        @(posedge clock);
        #1;
        clear = clr; ir = irv; mem_ready = mr; con_ff = cf;
        name_q.push_back(nm);
        vec_q.push_back(exp_vec);
    endtask

    task automatic checkOutput(input string nm, input logic [26:0] exp_vec);
        checks++;
        if (actual !== exp_vec) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nm, actual, exp_vec);
        end
    endtask

    always @(negedge clock) begin
        if (vec_q.size() != 0) checkOutput(name_q.pop_front(), vec_q.pop_front());
    end

    // Fetch with the previous instruction word still on ir; the new word appears at T3.
    task automatic fetch(input string tag, input logic [31:0] old_ir, input int waits,
                         input logic cf);
        applyStimulus({tag, ":T0"}, 1'b1, old_ir, 1'b0, cf, RUN | PC_OUT | MAR_IN | INC_PC | Z_IN);
        for (int i = 0; i < waits; i++)
            applyStimulus({tag, ":T1wait"}, 1'b1, old_ir, 1'b0, cf, RUN | Z_LOW_OUT | READ | MDR_IN);
        applyStimulus({tag, ":T1ready"}, 1'b1, old_ir, 1'b1, cf,
                      RUN | Z_LOW_OUT | READ | MDR_IN | PC_IN);
        applyStimulus({tag, ":T2"}, 1'b1, old_ir, 1'b0, cf, RUN | MDR_OUT | IR_IN);
    endtask

    task automatic exec3(input string tag, input logic [31:0] irv,
                         input logic [26:0] e3, input logic [26:0] e4, input logic [26:0] e5);
        applyStimulus({tag, ":T3"}, 1'b1, irv, 1'b0, 1'b0, RUN | e3);
        applyStimulus({tag, ":T4"}, 1'b1, irv, 1'b0, 1'b0, RUN | e4);
        applyStimulus({tag, ":T5"}, 1'b1, irv, 1'b0, 1'b0, RUN | e5);
    endtask

    task automatic runBranch(input string tag, input logic [31:0] prev, input logic cf);
        fetch(tag, prev, 0, cf);
        applyStimulus({tag, ":T3"}, 1'b1, 32'h98000000, 1'b0, cf, RUN | GRA | R_OUT | CON_IN);
        applyStimulus({tag, ":T4"}, 1'b1, 32'h98000000, 1'b0, cf, RUN | PC_OUT | Y_IN);
        applyStimulus({tag, ":T5"}, 1'b1, 32'h98000000, 1'b0, cf, RUN | C_OUT | Z_IN | alu(5'b00011));
        applyStimulus({tag, ":T6"}, 1'b1, 32'h98000000, 1'b1, cf,
                      RUN | Z_LOW_OUT | (cf ? PC_IN : NONE));
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        applyStimulus("reset0", 1'b0, 32'h0, 1'b0, 1'b0, NONE);
        applyStimulus("reset1", 1'b1, 32'h0, 1'b1, 1'b1, NONE);

        fetch("sub", 32'h0, 3, 1'b0);
        exec3("sub", 32'h20A20000, GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN | alu(5'b00100),
              Z_LOW_OUT | GRA | R_IN);

        fetch("add", 32'h20A20000, 0, 1'b0);
        exec3("add", 32'h18A20000, GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN | alu(5'b00011),
              Z_LOW_OUT | GRA | R_IN);

        fetch("ori", 32'h18A20000, 1, 1'b0);
        exec3("ori", 32'h70880005, GRB | R_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00110),
              Z_LOW_OUT | GRA | R_IN);

        fetch("andi", 32'h70880005, 0, 1'b0);
        exec3("andi", 32'h68880005, GRB | R_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00101),
              Z_LOW_OUT | GRA | R_IN);

        fetch("ldi", 32'h68880005, 0, 1'b0);
        exec3("ldi", 32'h08800010, GRB | BA_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00011),
              Z_LOW_OUT | GRA | R_IN);

        fetch("ld", 32'h08800010, 0, 1'b0);
        exec3("ld", 32'h00880010, GRB | BA_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00011),
              Z_LOW_OUT | MAR_IN);
        applyStimulus("ld:T6wait", 1'b1, 32'h00880010, 1'b0, 1'b0, RUN | READ | MDR_IN);
        applyStimulus("ld:T6wait", 1'b1, 32'h00880010, 1'b0, 1'b0, RUN | READ | MDR_IN);
        applyStimulus("ld:T6ready", 1'b1, 32'h00880010, 1'b1, 1'b0, RUN | READ | MDR_IN);
        applyStimulus("ld:T7", 1'b1, 32'h00880010, 1'b0, 1'b0, RUN | MDR_OUT | GRA | R_IN);

        fetch("st", 32'h00880010, 0, 1'b0);
        exec3("st", 32'h10880020, GRB | BA_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00011),
              Z_LOW_OUT | MAR_IN);
        applyStimulus("st:T6", 1'b1, 32'h10880020, 1'b0, 1'b0, RUN | GRA | R_OUT | MDR_IN);
        applyStimulus("st:T7wait", 1'b1, 32'h10880020, 1'b0, 1'b0, RUN | WRITE);
        applyStimulus("st:T7wait", 1'b1, 32'h10880020, 1'b0, 1'b0, RUN | WRITE);
        applyStimulus("st:T7ready", 1'b1, 32'h10880020, 1'b1, 1'b0, RUN | WRITE);

        runBranch("br_nt", 32'h10880020, 1'b0);
        runBranch("br_t", 32'h98000000, 1'b1);

        fetch("jr", 32'h98000000, 0, 1'b0);
        applyStimulus("jr:T3", 1'b1, 32'hA0800000, 1'b0, 1'b0, RUN | GRA | R_OUT | PC_IN);

        fetch("nop", 32'hA0800000, 0, 1'b0);
        applyStimulus("nop:T3", 1'b1, 32'hD0000000, 1'b0, 1'b0, RUN);

        fetch("illegal", 32'hD0000000, 0, 1'b0);
        applyStimulus("illegal:T3", 1'b1, 32'hF8000000, 1'b1, 1'b0, RUN | ILLEGAL);
        for (int i = 0; i < 20; i++)
            applyStimulus("illegal:halt", 1'b1, 32'hF8000000, 1'b1, 1'b1, ILLEGAL);
        applyStimulus("illegal:clear", 1'b0, 32'hF8000000, 1'b0, 1'b0, ILLEGAL);
        applyStimulus("illegal:reset", 1'b1, 32'hF8000000, 1'b0, 1'b0, NONE);

        fetch("ldclr", 32'hF8000000, 0, 1'b0);
        exec3("ldclr", 32'h00880010, GRB | BA_OUT | Y_IN, C_OUT | Z_IN | alu(5'b00011),
              Z_LOW_OUT | MAR_IN);
        applyStimulus("ldclr:T6wait", 1'b0, 32'h00880010, 1'b0, 1'b0, RUN | READ | MDR_IN);
        applyStimulus("ldclr:reset", 1'b1, 32'h00880010, 1'b1, 1'b0, NONE);

        fetch("halt", 32'h00880010, 0, 1'b0);
        applyStimulus("halt:T3", 1'b1, 32'hD8000000, 1'b0, 1'b0, RUN);
        applyStimulus("halt:hold", 1'b1, 32'hD8000000, 1'b1, 1'b1, NONE);
        applyStimulus("halt:hold", 1'b1, 32'h00000000, 1'b1, 1'b1, NONE);

        @(posedge clock);
        #1;
        checks++;
        if (vec_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", vec_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
